// File: rtl/bm_arbiter_pkg.sv
// Shared definitions for the branch-metric arbiter: default widths, frame length
// and FSM state encoding.
package bm_arbiter_pkg;

  localparam int BM_W_DEF      = 7;
  localparam int ID_W_DEF      = 4;
  localparam int FRAME_LEN_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } bm_state_t;

endpackage

// File: rtl/bm_arbiter_rr.sv
// Two-input round-robin arbiter; rr selects the winner only when both request,
// and flips only after such a contested grant.
module bm_rr_arb (
  input  logic en,
  input  logic req0,
  input  logic req1,
  input  logic rr,
  output logic gnt0,
  output logic gnt1,
  output logic rr_next
);

  logic contested;

  always_comb begin
    contested = req0 && req1;
    gnt0      = en && req0 && (!req1 || !rr);
    gnt1      = en && req1 && (!req0 || rr);
    rr_next   = (en && contested) ? ~rr : rr;
  end

endmodule

// File: rtl/bm_arbiter.sv
// Sequencer in front of the BM register stage: arbitrates two BMUs, stamps a
// wrapping data_id and holds the pair until the ACS stage accepts it.
module bm_arbiter
  import bm_arbiter_pkg::*;
#(
  parameter int BM_W      = BM_W_DEF,
  parameter int ID_W      = ID_W_DEF,
  parameter int FRAME_LEN = FRAME_LEN_DEF
) (
  input  logic            BMA_clk,
  input  logic            BMA_rst,
  input  logic            req0,
  input  logic [BM_W-1:0] bm0,
  output logic            gnt0,
  input  logic            req1,
  input  logic [BM_W-1:0] bm1,
  output logic            gnt1,
  input  logic            acs_ready,
  input  logic            flush,
  output logic            BM_valid,
  output logic [BM_W-1:0] BM_out,
  output logic [ID_W-1:0] data_id_out,
  output logic            frame_done,
  output logic            busy
);

  localparam logic [ID_W-1:0] LAST_ID = ID_W'(FRAME_LEN - 1);

  bm_state_t       state;
  logic [ID_W-1:0] id_cnt;
  logic            rr;
  logic            rr_next;
  logic            can_load;
  logic            load;
  logic            pop;

  always_comb begin
    can_load = (state != DRAIN) && !flush && (!BM_valid || acs_ready) && !BMA_rst;
    pop      = BM_valid && acs_ready;
    load     = gnt0 || gnt1;
    busy     = (state == RUN) || (state == DRAIN);
  end

  bm_rr_arb u_rr_arb (
    .en      (can_load),
    .req0    (req0),
    .req1    (req1),
    .rr      (rr),
    .gnt0    (gnt0),
    .gnt1    (gnt1),
    .rr_next (rr_next)
  );

  // Output register, id counter and FSM; a load in the same cycle as a pop
  // simply overwrites the register, so BM_valid stays high.
  always_ff @(posedge BMA_clk) begin
    if (BMA_rst) begin
      state       <= IDLE;
      BM_valid    <= 1'b0;
      BM_out      <= '0;
      data_id_out <= '0;
      frame_done  <= 1'b0;
      id_cnt      <= '0;
      rr          <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (load) begin
        BM_out      <= gnt0 ? bm0 : bm1;
        data_id_out <= id_cnt;
        BM_valid    <= 1'b1;
        frame_done  <= (id_cnt == LAST_ID);
        id_cnt      <= (id_cnt == LAST_ID) ? '0 : id_cnt + 1'b1;
        rr          <= rr_next;
      end else if (pop) begin
        BM_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (flush) begin
            id_cnt <= '0;
            rr     <= 1'b0;
          end else if (load) begin
            state <= RUN;
          end
        end
        RUN: begin
          if (flush)
            state <= DRAIN;
          else if (!load && (pop || !BM_valid))
            state <= IDLE;
        end
        DRAIN: begin
          // The pending metric is still delivered before realigning.
          if (!BM_valid || pop) begin
            id_cnt <= '0;
            rr     <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bm_arbiter.sv
// Directed self-checking bench for bm_arbiter: inputs change on the falling
// edge, combinational grants are checked #1 later, registers on the next fall.
module tb_bm_arbiter;

  logic       BMA_clk = 1'b0;
  logic       BMA_rst;
  logic       req0, req1, acs_ready, flush;
  logic [6:0] bm0, bm1;
  logic       gnt0, gnt1, BM_valid, frame_done, busy;
  logic [6:0] BM_out;
  logic [3:0] data_id_out;

  int checks   = 0;
  int failures = 0;

  always #5 BMA_clk = ~BMA_clk;

  bm_arbiter dut (
    .BMA_clk     (BMA_clk),
    .BMA_rst     (BMA_rst),
    .req0        (req0),
    .bm0         (bm0),
    .gnt0        (gnt0),
    .req1        (req1),
    .bm1         (bm1),
    .gnt1        (gnt1),
    .acs_ready   (acs_ready),
    .flush       (flush),
    .BM_valid    (BM_valid),
    .BM_out      (BM_out),
    .data_id_out (data_id_out),
    .frame_done  (frame_done),
    .busy        (busy)
  );

  task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic apply_stimulus(input logic r0, input logic [6:0] b0, input logic r1,
                                input logic [6:0] b1, input logic acs, input logic fl);
    req0 = r0; bm0 = b0; req1 = r1; bm1 = b1; acs_ready = acs; flush = fl;
  endtask

  task automatic do_reset();
    @(negedge BMA_clk);
    BMA_rst = 1'b1;
    apply_stimulus(0, 0, 0, 0, 1, 0);
    repeat (2) @(negedge BMA_clk);
    BMA_rst = 1'b0;
  endtask

  initial begin
    BMA_rst = 1'b1;
    apply_stimulus(1, 7'h15, 0, 0, 1, 0);

    // Reset with a pending request, then first transfer.
    repeat (2) @(negedge BMA_clk);
    #1;
    check_output("rst_gnt0", gnt0, 0);
    check_output("rst_valid", BM_valid, 0);
    check_output("rst_id", data_id_out, 0);
    check_output("rst_busy", busy, 0);
    BMA_rst = 1'b0;
    #1 check_output("first_gnt0", gnt0, 1);
    @(negedge BMA_clk);
    check_output("first_valid", BM_valid, 1);
    check_output("first_out", BM_out, 7'h15);
    check_output("first_id", data_id_out, 0);
    check_output("first_busy", busy, 1);
    apply_stimulus(0, 0, 0, 0, 1, 0);

    // Contention alternates starting with BMU0.
    do_reset();
    apply_stimulus(1, 7'h01, 1, 7'h02, 1, 0);
    for (int i = 0; i < 4; i++) begin
      #1;
      check_output("cont_gnt0", gnt0, (i % 2) == 0);
      check_output("cont_gnt1", gnt1, (i % 2) == 1);
      @(negedge BMA_clk);
      check_output("cont_out", BM_out, ((i % 2) == 0) ? 7'h01 : 7'h02);
      check_output("cont_id", data_id_out, i);
    end
    apply_stimulus(0, 0, 0, 0, 1, 0);

    // Backpressure holding id 5.
    do_reset();
    apply_stimulus(1, 7'h0A, 0, 0, 1, 0);
    repeat (6) @(negedge BMA_clk);
    check_output("bp_id5", data_id_out, 5);
    apply_stimulus(0, 7'h0A, 1, 7'h33, 0, 0);
    for (int i = 0; i < 3; i++) begin
      #1 check_output("bp_gnt1_blocked", gnt1, 0);
      @(negedge BMA_clk);
      check_output("bp_hold_out", BM_out, 7'h0A);
      check_output("bp_hold_id", data_id_out, 5);
      check_output("bp_hold_valid", BM_valid, 1);
    end
    acs_ready = 1'b1;
    #1 check_output("bp_gnt1_release", gnt1, 1);
    @(negedge BMA_clk);
    check_output("bp_new_out", BM_out, 7'h33);
    check_output("bp_new_id", data_id_out, 6);
    apply_stimulus(0, 0, 0, 0, 1, 0);

    // Wrap and frame_done.
    do_reset();
    apply_stimulus(1, 7'h44, 0, 0, 1, 0);
    for (int i = 0; i < 17; i++) begin
      @(negedge BMA_clk);
      check_output("wrap_id", data_id_out, i % 16);
      check_output("wrap_frame_done", frame_done, i == 15);
      check_output("wrap_valid", BM_valid, 1);
    end
    apply_stimulus(0, 0, 0, 0, 1, 0);
    @(negedge BMA_clk);
    check_output("pop_only_valid", BM_valid, 0);
    check_output("pop_only_out_kept", BM_out, 7'h44);

    // Flush mid-frame with id 9 held.
    do_reset();
    apply_stimulus(1, 7'h09, 0, 0, 1, 0);
    repeat (10) @(negedge BMA_clk);
    check_output("fl_id9", data_id_out, 9);
    apply_stimulus(1, 7'h11, 1, 7'h22, 0, 1);
    #1;
    check_output("fl_gnt0_blk", gnt0, 0);
    check_output("fl_gnt1_blk", gnt1, 0);
    @(negedge BMA_clk);
    flush = 1'b0;
    #1;
    check_output("drain_busy", busy, 1);
    check_output("drain_gnt0", gnt0, 0);
    check_output("drain_gnt1", gnt1, 0);
    check_output("drain_id", data_id_out, 9);
    acs_ready = 1'b1;
    #1 check_output("drain_pop_gnt0", gnt0, 0);
    @(negedge BMA_clk);
    check_output("drain_done_valid", BM_valid, 0);
    check_output("drain_done_busy", busy, 0);
    #1;
    check_output("post_fl_gnt0", gnt0, 1);
    check_output("post_fl_gnt1", gnt1, 0);
    @(negedge BMA_clk);
    check_output("post_fl_out", BM_out, 7'h11);
    check_output("post_fl_id", data_id_out, 0);
    apply_stimulus(0, 0, 0, 0, 1, 0);

    // Reset while RUN with frame_done high.
    do_reset();
    apply_stimulus(1, 7'h5A, 0, 0, 1, 0);
    repeat (16) @(negedge BMA_clk);
    check_output("mid_pre_fd", frame_done, 1);
    BMA_rst = 1'b1;
    #1 check_output("mid_rst_gnt0", gnt0, 0);
    @(negedge BMA_clk);
    check_output("mid_rst_valid", BM_valid, 0);
    check_output("mid_rst_id", data_id_out, 0);
    check_output("mid_rst_fd", frame_done, 0);
    check_output("mid_rst_busy", busy, 0);
    BMA_rst = 1'b0;
    @(negedge BMA_clk);
    check_output("mid_after_id", data_id_out, 0);
    check_output("mid_after_valid", BM_valid, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
